// File: rtl/note_pkg.sv
// Shared widths, FSM encodings and the latched note-event record used by
// the voice allocator and the note_player bank it drives.
package note_pkg;
    localparam int NOTE_W   = 6;
    localparam int DUR_W    = 6;
    localparam int STEREO_W = 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_GUARD = 2'd2;

    typedef struct packed {
        logic [NOTE_W-1:0]   note;
        logic [DUR_W-1:0]    duration;
        logic [STEREO_W-1:0] stereo;
    } note_evt_t;
endpackage

// File: rtl/rr_idle_picker.sv
// Combinational round-robin search: first idle voice at or above rr_ptr,
// wrapping around the voice bank.
module rr_idle_picker #(
    parameter int NUM_VOICES = 4
) (
    input  logic [NUM_VOICES-1:0]         idle_mask,
    input  logic [$clog2(NUM_VOICES)-1:0] rr_ptr,
    output logic [$clog2(NUM_VOICES)-1:0] sel,
    output logic                          found
);
    localparam int PTR_W = $clog2(NUM_VOICES);
    localparam logic [PTR_W:0] NV = (PTR_W+1)'(NUM_VOICES);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        sel   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_VOICES; k++) begin
            sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (sum >= NV)
                sum = sum - NV;
            idx = sum[PTR_W-1:0];
            if (!found && idle_mask[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end
endmodule

// File: rtl/voice_allocator.sv
// Polyphony scheduler: accepts note events and dispatches each to one idle
// note_player, tracking per-voice busy state and counting rests.
module voice_allocator
    import note_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter bit STEAL      = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play_enable,
    input  logic                  note_valid,
    input  logic [NOTE_W-1:0]     note_in,
    input  logic [DUR_W-1:0]      duration_in,
    input  logic [STEREO_W-1:0]   stereo_in,
    output logic                  note_ready,
    output logic [NUM_VOICES-1:0] voice_load,
    output logic [NOTE_W-1:0]     voice_note,
    output logic [DUR_W-1:0]      voice_duration,
    output logic [STEREO_W-1:0]   voice_stereo,
    input  logic [NUM_VOICES-1:0] voice_done,
    output logic [NUM_VOICES-1:0] voice_busy,
    output logic                  all_idle,
    output logic [7:0]            rest_count
);
    localparam int PTR_W = $clog2(NUM_VOICES);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_VOICES - 1);

    logic [1:0]            state, state_nxt;
    logic [PTR_W-1:0]      rr_ptr, pick_sel, sel;
    logic                  pick_found;
    logic                  accept, rest, dispatch, ready_nxt;
    logic [NUM_VOICES-1:0] idle_mask, sel_onehot, load_set, busy_nxt;
    note_evt_t             evt_q;

    assign idle_mask = ~voice_busy;

    rr_idle_picker #(.NUM_VOICES(NUM_VOICES)) u_picker (
        .idle_mask (idle_mask),
        .rr_ptr    (rr_ptr),
        .sel       (pick_sel),
        .found     (pick_found)
    );

    // With nothing idle the only way to get here is STEAL, which takes rr_ptr.
    assign sel        = pick_found ? pick_sel : rr_ptr;
    assign sel_onehot = NUM_VOICES'(1) << sel;

    assign accept   = note_valid & note_ready & (state == ST_IDLE);
    assign rest     = accept & (duration_in == '0);
    assign dispatch = accept & ~rest;

    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE:  state_nxt = dispatch ? ST_LOAD : ST_IDLE;
            ST_LOAD:  state_nxt = ST_GUARD;
            ST_GUARD: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // A load in either the accept or the LOAD cycle overrides a same-cycle done.
    assign load_set  = (dispatch ? sel_onehot : '0) | ((state == ST_LOAD) ? voice_load : '0);
    assign busy_nxt  = (voice_busy & ~voice_done) | load_set;
    assign ready_nxt = (state_nxt == ST_IDLE) & play_enable & (~(&busy_nxt) | STEAL);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            voice_busy <= '0;
            voice_load <= '0;
            note_ready <= 1'b0;
            all_idle   <= 1'b1;
            rest_count <= '0;
            evt_q      <= '0;
        end else begin
            state      <= state_nxt;
            voice_busy <= busy_nxt;
            voice_load <= dispatch ? sel_onehot : '0;
            note_ready <= ready_nxt;
            all_idle   <= (busy_nxt == '0) & (state_nxt == ST_IDLE);
            if (rest)
                rest_count <= rest_count + 8'd1;
            if (dispatch) begin
                evt_q  <= '{note: note_in, duration: duration_in, stereo: stereo_in};
                rr_ptr <= (sel == LAST) ? '0 : sel + PTR_W'(1);
            end
        end
    end

    assign voice_note     = evt_q.note;
    assign voice_duration = evt_q.duration;
    assign voice_stereo   = evt_q.stereo;
endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: a STEAL=0 and a STEAL=1 instance share stimulus
// and are checked every cycle against a cycle-level behavioural model.
module tb_voice_allocator;
    localparam int NV = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, play, valid;
    logic [5:0] note, dur;
    logic [1:0] st;
    logic [3:0] done;

    logic [1:0]       rdy, aidle;
    logic [1:0][3:0]  vload, vbusy;
    logic [1:0][5:0]  vnote, vdur;
    logic [1:0][1:0]  vst;
    logic [1:0][7:0]  rcnt;

    voice_allocator #(.NUM_VOICES(NV), .STEAL(1'b0)) dut0 (
        .clk(clk), .reset(rst_n), .play_enable(play), .note_valid(valid),
        .note_in(note), .duration_in(dur), .stereo_in(st), .note_ready(rdy[0]),
        .voice_load(vload[0]), .voice_note(vnote[0]), .voice_duration(vdur[0]),
        .voice_stereo(vst[0]), .voice_done(done), .voice_busy(vbusy[0]),
        .all_idle(aidle[0]), .rest_count(rcnt[0]));

    voice_allocator #(.NUM_VOICES(NV), .STEAL(1'b1)) dut1 (
        .clk(clk), .reset(rst_n), .play_enable(play), .note_valid(valid),
        .note_in(note), .duration_in(dur), .stereo_in(st), .note_ready(rdy[1]),
        .voice_load(vload[1]), .voice_note(vnote[1]), .voice_duration(vdur[1]),
        .voice_stereo(vst[1]), .voice_done(done), .voice_busy(vbusy[1]),
        .all_idle(aidle[1]), .rest_count(rcnt[1]));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: busy flags per voice, cycles left until the scheduler
    // can take a new note, and the round-robin start position.
    bit         m_busy[2][NV];
    int         m_cool[2];
    int         m_rr[2];
    logic [3:0] m_load[2];
    logic [5:0] m_note[2], m_dur[2];
    logic [1:0] m_st[2];
    int         m_rest[2];
    bit         m_ready[2], m_idle[2];

    task automatic model_step(int d, bit steal);
        bit pre[NV];
        int pick;
        bit any_idle, any_busy;
        logic [3:0] newload;
        if (!rst_n) begin
            for (int v = 0; v < NV; v++) m_busy[d][v] = 0;
            m_cool[d] = 0; m_rr[d] = 0; m_load[d] = '0;
            m_note[d] = '0; m_dur[d] = '0; m_st[d] = '0; m_rest[d] = 0;
            m_ready[d] = 0; m_idle[d] = 1;
            return;
        end
        for (int v = 0; v < NV; v++) pre[v] = m_busy[d][v];
        for (int v = 0; v < NV; v++) begin
            if (done[v]) m_busy[d][v] = 0;
            if (m_load[d][v]) m_busy[d][v] = 1;
        end
        newload = '0;
        if (valid && m_ready[d] && dur == 0) begin
            m_rest[d] = (m_rest[d] + 1) % 256;
        end else if (valid && m_ready[d]) begin
            pick = -1;
            for (int k = 0; k < NV; k++)
                if (pick < 0 && !pre[(m_rr[d] + k) % NV]) pick = (m_rr[d] + k) % NV;
            if (pick < 0) pick = m_rr[d];
            newload[pick] = 1'b1;
            m_busy[d][pick] = 1;
            m_rr[d] = (pick + 1) % NV;
            m_note[d] = note; m_dur[d] = dur; m_st[d] = st;
            m_cool[d] = 2;
        end else if (m_cool[d] > 0) begin
            m_cool[d]--;
        end
        m_load[d] = newload;
        any_idle = 0; any_busy = 0;
        for (int v = 0; v < NV; v++) begin
            if (m_busy[d][v]) any_busy = 1; else any_idle = 1;
        end
        m_ready[d] = (m_cool[d] == 0) && play && (any_idle || steal);
        m_idle[d]  = (m_cool[d] == 0) && !any_busy;
    endtask

    function automatic logic [3:0] busy_vec(int d);
        logic [3:0] b;
        for (int v = 0; v < NV; v++) b[v] = m_busy[d][v];
        return b;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step(0, 1'b0);
        model_step(1, 1'b1);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d note_ready", d), 32'(rdy[d]), 32'(m_ready[d]));
            chk($sformatf("d%0d voice_load", d), 32'(vload[d]), 32'(m_load[d]));
            chk($sformatf("d%0d voice_busy", d), 32'(vbusy[d]), 32'(busy_vec(d)));
            chk($sformatf("d%0d voice_note", d), 32'(vnote[d]), 32'(m_note[d]));
            chk($sformatf("d%0d voice_duration", d), 32'(vdur[d]), 32'(m_dur[d]));
            chk($sformatf("d%0d voice_stereo", d), 32'(vst[d]), 32'(m_st[d]));
            chk($sformatf("d%0d all_idle", d), 32'(aidle[d]), 32'(m_idle[d]));
            chk($sformatf("d%0d rest_count", d), 32'(rcnt[d]), 32'(m_rest[d]));
        end
    endtask

    typedef struct {
        bit r, p, v;
        logic [5:0] du;
        logic [3:0] dn;
        bit r0; logic [3:0] l0, b0; bit i0;
        bit r1; logic [3:0] l1, b1;
    } vec_t;

    function automatic vec_t mk(bit r, bit p, bit v, logic [5:0] du, logic [3:0] dn,
                                bit r0, logic [3:0] l0, logic [3:0] b0, bit i0,
                                bit r1, logic [3:0] l1, logic [3:0] b1);
        vec_t t;
        t.r = r; t.p = p; t.v = v; t.du = du; t.dn = dn;
        t.r0 = r0; t.l0 = l0; t.b0 = b0; t.i0 = i0;
        t.r1 = r1; t.l1 = l1; t.b1 = b1;
        return t;
    endfunction

    vec_t tbl[22];

    initial begin
        // rst  play valid dur  done | ready0 load0 busy0 idle0 | ready1 load1 busy1
        tbl[0]  = mk(0, 1, 0, 0, 4'h0,  0, 4'h0, 4'h0, 1,  0, 4'h0, 4'h0);
        tbl[1]  = mk(0, 1, 0, 0, 4'h0,  0, 4'h0, 4'h0, 1,  0, 4'h0, 4'h0);
        tbl[2]  = mk(0, 1, 0, 0, 4'h0,  0, 4'h0, 4'h0, 1,  0, 4'h0, 4'h0);
        tbl[3]  = mk(1, 1, 0, 0, 4'h0,  1, 4'h0, 4'h0, 1,  1, 4'h0, 4'h0);
        tbl[4]  = mk(1, 1, 1, 8, 4'h0,  0, 4'h1, 4'h1, 0,  0, 4'h1, 4'h1);
        tbl[5]  = mk(1, 1, 1, 8, 4'h0,  0, 4'h0, 4'h1, 0,  0, 4'h0, 4'h1);
        tbl[6]  = mk(1, 1, 1, 8, 4'h0,  1, 4'h0, 4'h1, 0,  1, 4'h0, 4'h1);
        tbl[7]  = mk(1, 1, 1, 8, 4'h0,  0, 4'h2, 4'h3, 0,  0, 4'h2, 4'h3);
        tbl[8]  = mk(1, 1, 1, 8, 4'h0,  0, 4'h0, 4'h3, 0,  0, 4'h0, 4'h3);
        tbl[9]  = mk(1, 1, 1, 8, 4'h0,  1, 4'h0, 4'h3, 0,  1, 4'h0, 4'h3);
        tbl[10] = mk(1, 1, 1, 8, 4'h0,  0, 4'h4, 4'h7, 0,  0, 4'h4, 4'h7);
        tbl[11] = mk(1, 1, 1, 8, 4'h0,  0, 4'h0, 4'h7, 0,  0, 4'h0, 4'h7);
        tbl[12] = mk(1, 1, 1, 8, 4'h0,  1, 4'h0, 4'h7, 0,  1, 4'h0, 4'h7);
        tbl[13] = mk(1, 1, 1, 8, 4'h0,  0, 4'h8, 4'hF, 0,  0, 4'h8, 4'hF);
        tbl[14] = mk(1, 1, 1, 8, 4'h0,  0, 4'h0, 4'hF, 0,  0, 4'h0, 4'hF);
        tbl[15] = mk(1, 1, 1, 8, 4'h0,  0, 4'h0, 4'hF, 0,  1, 4'h0, 4'hF);
        tbl[16] = mk(1, 1, 1, 8, 4'h0,  0, 4'h0, 4'hF, 0,  0, 4'h1, 4'hF);
        tbl[17] = mk(1, 1, 1, 8, 4'h4,  1, 4'h0, 4'hB, 0,  0, 4'h0, 4'hB);
        tbl[18] = mk(1, 1, 1, 8, 4'h0,  0, 4'h4, 4'hF, 0,  1, 4'h0, 4'hB);
        tbl[19] = mk(1, 1, 0, 8, 4'h0,  0, 4'h0, 4'hF, 0,  1, 4'h0, 4'hB);
        tbl[20] = mk(1, 1, 0, 8, 4'h0,  0, 4'h0, 4'hF, 0,  1, 4'h0, 4'hB);
        tbl[21] = mk(1, 1, 0, 8, 4'hF,  1, 4'h0, 4'h0, 1,  1, 4'h0, 4'h0);

        rst_n = 0; play = 1; valid = 0; note = 6'd20; dur = 0; st = 2'b01; done = 0;

        // Reset, four back-to-back dispatches, stall vs steal when full
        for (int i = 0; i < 22; i++) begin
            rst_n = tbl[i].r; play = tbl[i].p; valid = tbl[i].v;
            dur = tbl[i].du; done = tbl[i].dn;
            cycle();
            chk($sformatf("tbl%0d ready0", i), 32'(rdy[0]), 32'(tbl[i].r0));
            chk($sformatf("tbl%0d load0", i), 32'(vload[0]), 32'(tbl[i].l0));
            chk($sformatf("tbl%0d busy0", i), 32'(vbusy[0]), 32'(tbl[i].b0));
            chk($sformatf("tbl%0d idle0", i), 32'(aidle[0]), 32'(tbl[i].i0));
            chk($sformatf("tbl%0d ready1", i), 32'(rdy[1]), 32'(tbl[i].r1));
            chk($sformatf("tbl%0d load1", i), 32'(vload[1]), 32'(tbl[i].l1));
            chk($sformatf("tbl%0d busy1", i), 32'(vbusy[1]), 32'(tbl[i].b1));
        end
        done = 0;

        // Rests: one, then 255 more to wrap the counter
        valid = 1; dur = 0;
        cycle();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d rest first", d), 32'(rcnt[d]), 32'd1);
            chk($sformatf("d%0d rest no load", d), 32'(vload[d]), 32'd0);
        end
        for (int i = 0; i < 255; i++) cycle();
        valid = 0;
        for (int d = 0; d < 2; d++)
            chk($sformatf("d%0d rest wrap", d), 32'(rcnt[d]), 32'd0);

        // Done pulse to voice 1 coinciding with its load
        rst_n = 0; cycle(); cycle(); rst_n = 1; cycle();
        valid = 1; dur = 6'd5; note = 6'd7; st = 2'b10; cycle();
        valid = 0; cycle(); cycle();
        valid = 1; done = 4'b0010; cycle();
        for (int d = 0; d < 2; d++)
            chk($sformatf("d%0d load v1", d), 32'(vload[d]), 32'h2);
        valid = 0; cycle();
        done = 0;
        for (int d = 0; d < 2; d++)
            chk($sformatf("d%0d busy after done+load", d), 32'(vbusy[d]), 32'h3);
        cycle();
        for (int d = 0; d < 2; d++)
            chk($sformatf("d%0d busy held", d), 32'(vbusy[d]), 32'h3);

        // Reset landing in the LOAD cycle
        valid = 1; dur = 6'd9; note = 6'd33; st = 2'b01; cycle();
        for (int d = 0; d < 2; d++)
            chk($sformatf("d%0d load v2", d), 32'(vload[d]), 32'h4);
        valid = 0; rst_n = 0; cycle();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d rst load", d), 32'(vload[d]), 32'h0);
            chk($sformatf("d%0d rst busy", d), 32'(vbusy[d]), 32'h0);
            chk($sformatf("d%0d rst note", d), 32'(vnote[d]), 32'h0);
            chk($sformatf("d%0d rst ready", d), 32'(rdy[d]), 32'h0);
            chk($sformatf("d%0d rst all_idle", d), 32'(aidle[d]), 32'h1);
        end
        rst_n = 1; cycle();

        // Randomized traffic with pauses, done pulses and occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            play  = ($urandom_range(0, 9) != 0);
            valid = $urandom_range(0, 1);
            note  = 6'($urandom);
            dur   = ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            st    = $urandom_range(0, 1) ? 2'b10 : 2'b01;
            for (int v = 0; v < NV; v++) done[v] = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
